// File: rtl/ps2_host_pkg.sv
// Shared types and protocol constants for the PS/2 mouse host sequencer.
package ps2_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_TX_WAIT,
    ST_ACK_WAIT,
    ST_STREAM_B0,
    ST_STREAM_B1,
    ST_STREAM_B2,
    ST_ERROR
  } state_e;

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;

  function automatic logic in_stream(input state_e s);
    return (s == ST_STREAM_B0) || (s == ST_STREAM_B1) || (s == ST_STREAM_B2);
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Line controls, transmitter/receiver handshake and packet outputs of the host sequencer.
interface ps2_host_ctrl_if;

  logic       Start;
  logic       Done;
  logic       Interrupt;
  logic [7:0] ReadVal;
  logic       Clk_T;
  logic       Clk_Out;
  logic       D_T;
  logic       Load;
  logic [7:0] LoadVal;
  logic       Ready;
  logic       Packet_Valid;
  logic [2:0] Buttons;
  logic [8:0] Dx;
  logic [8:0] Dy;
  logic [1:0] Overflow;
  logic       Error;

  modport master (
    input  Start, Done, Interrupt, ReadVal,
    output Clk_T, Clk_Out, D_T, Load, LoadVal, Ready, Packet_Valid,
           Buttons, Dx, Dy, Overflow, Error
  );

  modport slave (
    output Start, Done, Interrupt, ReadVal,
    input  Clk_T, Clk_Out, D_T, Load, LoadVal, Ready, Packet_Valid,
           Buttons, Dx, Dy, Overflow, Error
  );

endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge pulse for PS/2-domain levels.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  // [0],[1] synchroniser stages, [2] previous synchronised value
  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign rise_c = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 mouse host: enables data reporting via the inhibit/RTS/send handshake, then frames 3-byte packets.
module ps2_host_ctrl
  import ps2_host_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  ps2_host_ctrl_if.master  bus
);

  localparam int unsigned CNT_MAX0 = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 2);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [7:0]           b0_q, b0_d, b1_q, b1_d;
  logic                 clk_t_q, clk_t_d, d_t_q, d_t_d, load_q, load_d;
  logic [7:0]           load_val_q, load_val_d;
  logic                 ready_q, ready_d, pkt_valid_q, pkt_valid_d, error_q, error_d;
  logic [2:0]           buttons_q, buttons_d;
  logic [8:0]           dx_q, dx_d, dy_q, dy_d;
  logic [1:0]           ovf_q, ovf_d;
  logic                 done_evt, rx_evt, timed_c, tmo_c;

  ps2_edge_sync u_done_sync (.clk(CLK), .rst(Reset), .din(bus.Done),      .rise_c(done_evt));
  ps2_edge_sync u_rx_sync   (.clk(CLK), .rst(Reset), .din(bus.Interrupt), .rise_c(rx_evt));

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ovf_d       = ovf_q;
    pkt_valid_d = 1'b0;
    tmo_c       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.Start) begin
          state_d = ST_INHIBIT;
          retry_d = '0;
        end
      end
      ST_INHIBIT: if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) state_d = ST_RTS;
      ST_RTS:     if (cnt_q == CNT_W'(RTS_CYCLES - 1))     state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (done_evt)   state_d = ST_ACK_WAIT;
        else if (tmo_c) state_d = ST_ERROR;
      end
      ST_ACK_WAIT: begin
        if (rx_evt) begin
          case (bus.ReadVal)
            RSP_ACK:    state_d = ST_STREAM_B0;
            RSP_RESEND: begin
              if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ST_INHIBIT;
              end else begin
                state_d = ST_ERROR;
              end
            end
            RSP_ERROR:  state_d = ST_ERROR;
            default:    state_d = ST_ERROR;
          endcase
        end else if (tmo_c) begin
          state_d = ST_ERROR;
        end
      end
      // Bytes without the always-one bit 3 cannot start a packet; drop them to resynchronise
      ST_STREAM_B0: begin
        if (rx_evt && bus.ReadVal[3]) begin
          b0_d    = bus.ReadVal;
          state_d = ST_STREAM_B1;
        end
      end
      ST_STREAM_B1: begin
        if (rx_evt) begin
          b1_d    = bus.ReadVal;
          state_d = ST_STREAM_B2;
        end
      end
      ST_STREAM_B2: begin
        if (rx_evt) begin
          buttons_d   = b0_q[2:0];
          dx_d        = {b0_q[4], b1_q};
          dy_d        = {b0_q[5], bus.ReadVal};
          ovf_d       = b0_q[7:6];
          pkt_valid_d = 1'b1;
          state_d     = ST_STREAM_B0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    timed_c = (state_q == ST_INHIBIT) || (state_q == ST_RTS) ||
              (state_q == ST_TX_WAIT) || (state_q == ST_ACK_WAIT);
    cnt_d   = (timed_c && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

    // Line controls decode the current state, so Load and the clock release coincide
    clk_t_d    = !((state_q == ST_INHIBIT) || (state_q == ST_RTS));
    d_t_d      = !((state_q == ST_RTS) || (state_q == ST_TX_WAIT));
    load_d     = (state_q == ST_TX_WAIT) && (cnt_q == '0);
    load_val_d = CMD_ENABLE;
    ready_d    = in_stream(state_q);
    error_d    = (state_q == ST_ERROR);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      clk_t_q     <= 1'b1;
      d_t_q       <= 1'b1;
      load_q      <= 1'b0;
      load_val_q  <= CMD_ENABLE;
      ready_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      error_q     <= 1'b0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      clk_t_q     <= clk_t_d;
      d_t_q       <= d_t_d;
      load_q      <= load_d;
      load_val_q  <= load_val_d;
      ready_q     <= ready_d;
      pkt_valid_q <= pkt_valid_d;
      error_q     <= error_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.Clk_T        = clk_t_q;
  assign bus.Clk_Out      = 1'b0;
  assign bus.D_T          = d_t_q;
  assign bus.Load         = load_q;
  assign bus.LoadVal      = load_val_q;
  assign bus.Ready        = ready_q;
  assign bus.Packet_Valid = pkt_valid_q;
  assign bus.Buttons      = buttons_q;
  assign bus.Dx           = dx_q;
  assign bus.Dy           = dy_q;
  assign bus.Overflow     = ovf_q;
  assign bus.Error        = error_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: mouse-side stimulus with a packet reference model built from the byte mapping rules.
module tb_ps2_host_ctrl;
  import ps2_host_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned RTS = 50;
  localparam int unsigned TMO = 3000;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [22:0] cap[$];

  ps2_host_ctrl_if bus ();

  ps2_host_ctrl #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (3)
  ) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Record every packet the DUT reports as {Buttons, Dx, Dy, Overflow}
  always @(negedge clk)
    if (bus.Packet_Valid === 1'b1) cap.push_back({bus.Buttons, bus.Dx, bus.Dy, bus.Overflow});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Movement is a signed 9-bit value: byte value minus 256 when the sign bit is set
  function automatic logic [22:0] pkt_model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = int'(b1) - (b0[4] ? 256 : 0);
    dy = int'(b2) - (b0[5] ? 256 : 0);
    return {b0[2:0], 9'(dx), 9'(dy), b0[7], b0[6]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.ReadVal   = b;
    bus.Interrupt = 1'b1;
    repeat (6) @(negedge clk);
    bus.Interrupt = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic give_done(input string tag);
    @(negedge clk);
    bus.Done = 1'b1;
    repeat (6) @(negedge clk);
    bus.Done = 1'b0;
    check({tag, "_dt_release"}, 32'(bus.D_T), 32'd1);
  endtask

  // Clock-only low phase, then clock+data low, then one Load with the clock released
  task automatic measure_handshake(input string tag);
    int c_inh, c_rts;
    bit got;
    c_inh = 0; c_rts = 0; got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      if (bus.Load === 1'b1)                        got = 1;
      else if (bus.Clk_T === 1'b0 && bus.D_T === 1'b1) c_inh++;
      else if (bus.Clk_T === 1'b0 && bus.D_T === 1'b0) c_rts++;
    end
    check({tag, "_load_seen"}, 32'(got), 32'd1);
    check({tag, "_inhibit_len"}, 32'(c_inh), 32'(INH));
    check({tag, "_rts_len"}, 32'(c_rts), 32'(RTS));
    check({tag, "_load_clk_t"}, 32'(bus.Clk_T), 32'd1);
    check({tag, "_load_d_t"}, 32'(bus.D_T), 32'd0);
    check({tag, "_loadval"}, 32'(bus.LoadVal), 32'hF4);
    @(negedge clk);
    check({tag, "_load_single"}, 32'(bus.Load), 32'd0);
  endtask

  task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [22:0] exp);
    logic [22:0] got;
    cap.delete();
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    check({tag, "_pv_count"}, 32'(cap.size()), 32'd1);
    got = (cap.size() > 0) ? cap[0] : '1;
    check({tag, "_fields"}, 32'(got), 32'(exp));
  endtask

  initial begin
    logic [7:0]  b0, b1, b2, sb;
    logic [22:0] last_exp;
    int          ns, n, lows;

    rst = 1'b1;
    bus.Start = 1'b0; bus.Done = 1'b0; bus.Interrupt = 1'b0; bus.ReadVal = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_clk_t",   32'(bus.Clk_T), 32'd1);
    check("rst_clk_out", 32'(bus.Clk_Out), 32'd0);
    check("rst_d_t",     32'(bus.D_T), 32'd1);
    check("rst_load",    32'(bus.Load), 32'd0);
    check("rst_loadval", 32'(bus.LoadVal), 32'hF4);
    check("rst_status",  32'({bus.Ready, bus.Packet_Valid, bus.Error}), 32'd0);
    check("rst_pkt",     32'({bus.Buttons, bus.Dx, bus.Dy, bus.Overflow}), 32'd0);
    rst = 1'b0;

    // Enable sequence acknowledged with 0xFA
    pulse_start();
    measure_handshake("init");
    give_done("init");
    send_byte(RSP_ACK);
    check("ack_ready", 32'(bus.Ready), 32'd1);
    check("ack_error", 32'(bus.Error), 32'd0);

    send_packet("pkt_a", 8'h09, 8'h05, 8'hFE, {3'b001, 9'h005, 9'h0FE, 2'b00});
    send_packet("pkt_neg_dy", 8'h29, 8'h05, 8'hFE, {3'b001, 9'h005, 9'h1FE, 2'b00});
    send_byte(8'h00);
    check("stray_hold", 32'({bus.Buttons, bus.Dx, bus.Dy, bus.Overflow}),
          32'({3'b001, 9'h005, 9'h1FE, 2'b00}));
    send_packet("pkt_b", 8'h38, 8'h80, 8'h01, {3'b000, 9'h180, 9'h101, 2'b00});
    last_exp = {3'b000, 9'h180, 9'h101, 2'b00};

    // Random packets with random stray bytes in between
    for (int p = 0; p < 20; p++) begin
      ns = int'($urandom_range(0, 2));
      for (int s = 0; s < ns; s++) begin
        sb = 8'($urandom) & 8'hF7;
        send_byte(sb);
      end
      check("rand_hold", 32'({bus.Buttons, bus.Dx, bus.Dy, bus.Overflow}), 32'(last_exp));
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      last_exp = pkt_model(b0, b1, b2);
      send_packet("rand_pkt", b0, b1, b2, last_exp);
    end

    pulse_start();
    repeat (10) @(negedge clk);
    check("stream_start_ignored_clk", 32'(bus.Clk_T), 32'd1);
    check("stream_start_ignored_rdy", 32'(bus.Ready), 32'd1);

    // Four resend responses: three re-inhibits, then ERROR
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    measure_handshake("retry0");
    for (int r = 0; r < 4; r++) begin
      give_done("retry");
      if (r < 3) begin
        fork
          send_byte(RSP_RESEND);
          measure_handshake("reinhibit");
        join
      end else begin
        send_byte(RSP_RESEND);
      end
    end
    check("retry_error", 32'(bus.Error), 32'd1);
    check("retry_lines", 32'({bus.Clk_T, bus.D_T}), 32'b11);
    check("retry_ready", 32'(bus.Ready), 32'd0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.Clk_T !== 1'b1) lows++;
    end
    check("error_no_reinhibit", 32'(lows), 32'd0);

    // No Done: TX_WAIT times out
    pulse_start();
    check("err_start_clears", 32'(bus.Error), 32'd1);
    measure_handshake("tx_tmo");
    n = 1;
    for (int i = 0; i < 5000; i++) begin
      if (bus.Error === 1'b1) break;
      @(negedge clk);
      n++;
    end
    check("tx_timeout_len", 32'(n), 32'(TMO));

    // Done but no response: ACK_WAIT times out
    pulse_start();
    measure_handshake("ack_tmo");
    bus.Done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.D_T === 1'b1) break;
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      if (bus.Error === 1'b1) break;
      @(negedge clk);
      n++;
    end
    bus.Done = 1'b0;
    check("ack_timeout_len", 32'(n), 32'(TMO));

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_clears_error", 32'(bus.Error), 32'd0);

    // Start coinciding with a receiver event in IDLE: the byte is dropped
    bus.ReadVal   = RSP_ACK;
    bus.Interrupt = 1'b1;
    repeat (2) @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start     = 1'b0;
    bus.Interrupt = 1'b0;
    measure_handshake("idle_start_rx");

    // Reset while waiting for Done releases the lines on the next edge
    repeat (3) @(negedge clk);
    check("tx_wait_d_t", 32'(bus.D_T), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_lines", 32'({bus.Clk_T, bus.D_T, bus.Load}), 32'b110);
    check("rst_tx_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Clk_T !== 1'b1 || bus.D_T !== 1'b1) lows++;
    end
    check("rst_tx_stays_idle", 32'(lows), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
